// File: rtl/target_seq_pkg.sv
// Shared encodings, register-block defaults and pin decode for the target power sequencer.
package target_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        SEQ_OFF       = 3'd0,
        SEQ_SETTLE    = 3'd1,
        SEQ_RST_HOLD  = 3'd2,
        SEQ_ON        = 3'd3,
        SEQ_DISCHARGE = 3'd4
    } seq_state_e;

    localparam logic [STATE_W-1:0] ST_OFF       = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd1;
    localparam logic [STATE_W-1:0] ST_RST_HOLD  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ON        = 3'd3;
    localparam logic [STATE_W-1:0] ST_DISCHARGE = 3'd4;

    localparam int unsigned DEF_SETTLE = 1000;
    localparam int unsigned DEF_RST    = 100;
    localparam int unsigned DEF_OFF    = 10000;

    typedef struct packed {
        logic npower;
        logic highz;
        logic drive_en;
        logic nrst;
        logic inhibit;
        logic busy;
    } pin_ctrl_t;

    localparam pin_ctrl_t PINS_RESET = '{npower: 1'b1, highz: 1'b1, drive_en: 1'b0,
                                         nrst: 1'b1, inhibit: 1'b1, busy: 1'b0};

    // Target-facing pin levels for each sequencer state.
    function automatic pin_ctrl_t decode_pins(input logic [STATE_W-1:0] st);
        pin_ctrl_t p;
        p = PINS_RESET;
        case (st)
            ST_SETTLE, ST_RST_HOLD: begin
                p.npower   = 1'b0;
                p.highz    = 1'b0;
                p.drive_en = 1'b1;
                p.nrst     = 1'b0;
                p.inhibit  = 1'b1;
                p.busy     = 1'b1;
            end
            ST_ON: begin
                p.npower   = 1'b0;
                p.highz    = 1'b0;
                p.drive_en = 1'b0;
                p.nrst     = 1'b1;
                p.inhibit  = 1'b0;
                p.busy     = 1'b0;
            end
            ST_DISCHARGE: begin
                p.busy     = 1'b1;
            end
            default: p = PINS_RESET;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/target_pwr_seq_down_counter.sv
// Shared dwell down-counter: loads on state entry, counts to zero and holds there.
module seq_down_counter #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/target_pwr_seq.sv
// Target power/reset sequencer: power-up with nRST hold, reset pulses, enforced off time.
module target_pwr_seq
    import target_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwr_en,
    input  logic             autorst,
    input  logic             rst_req,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic [CNT_W-1:0] rst_cycles,
    input  logic [CNT_W-1:0] off_cycles,
    output logic             target_npower,
    output logic             target_highz,
    output logic             nrst_drive_en,
    output logic             nrst_out,
    output logic             trig_inhibit,
    output logic             busy,
    output logic             ready_pulse,
    output logic [2:0]       state_o
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_nxt;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_zero_c;
    pin_ctrl_t          pins_nxt;
    pin_ctrl_t          pins_q;
    logic               ready_nxt;
    logic               ready_q;

    // A configured count of zero still dwells one cycle.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [CNT_W-1:0] cfg);
        return (cfg == '0) ? '0 : cfg - CNT_W'(1);
    endfunction

    seq_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero_c   (cnt_zero_c)
    );

    // Next state, counter load on entry, and next registered output values.
    always_comb begin
        state_nxt    = state_q;
        cnt_load_val = '0;
        case (state_q)
            ST_OFF: begin
                if (pwr_en) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!pwr_en)         state_nxt = ST_DISCHARGE;
                else if (cnt_zero_c) state_nxt = autorst ? ST_RST_HOLD : ST_ON;
            end
            ST_RST_HOLD: begin
                if (!pwr_en)         state_nxt = ST_DISCHARGE;
                else if (cnt_zero_c) state_nxt = ST_ON;
            end
            ST_ON: begin
                if (!pwr_en)      state_nxt = ST_DISCHARGE;
                else if (rst_req) state_nxt = ST_RST_HOLD;
            end
            ST_DISCHARGE: begin
                if (cnt_zero_c) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase

        cnt_load = (state_nxt != state_q);
        case (state_nxt)
            ST_SETTLE:    cnt_load_val = dwell_load(settle_cycles);
            ST_RST_HOLD:  cnt_load_val = dwell_load(rst_cycles);
            ST_DISCHARGE: cnt_load_val = dwell_load(off_cycles);
            default:      cnt_load_val = '0;
        endcase

        pins_nxt  = decode_pins(state_nxt);
        ready_nxt = (state_nxt == ST_ON) && (state_q != ST_ON);
    end

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            pins_q  <= PINS_RESET;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pins_q  <= pins_nxt;
            ready_q <= ready_nxt;
        end
    end

    assign target_npower = pins_q.npower;
    assign target_highz  = pins_q.highz;
    assign nrst_drive_en = pins_q.drive_en;
    assign nrst_out      = pins_q.nrst;
    assign trig_inhibit  = pins_q.inhibit;
    assign busy          = pins_q.busy;
    assign ready_pulse   = ready_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_target_pwr_seq.sv
// Directed bench for target_pwr_seq with a dwell-time reference model and per-cycle compare.
module tb_target_pwr_seq;

    localparam int unsigned CNT_W = 24;

    logic             clk;
    logic             reset_n;
    logic             pwr_en;
    logic             autorst;
    logic             rst_req;
    logic [CNT_W-1:0] settle_cycles;
    logic [CNT_W-1:0] rst_cycles;
    logic [CNT_W-1:0] off_cycles;
    logic             target_npower;
    logic             target_highz;
    logic             nrst_drive_en;
    logic             nrst_out;
    logic             trig_inhibit;
    logic             busy;
    logic             ready_pulse;
    logic [2:0]       state_o;

    int total = 0;
    int bad   = 0;

    target_pwr_seq #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pwr_en        (pwr_en),
        .autorst       (autorst),
        .rst_req       (rst_req),
        .settle_cycles (settle_cycles),
        .rst_cycles    (rst_cycles),
        .off_cycles    (off_cycles),
        .target_npower (target_npower),
        .target_highz  (target_highz),
        .nrst_drive_en (nrst_drive_en),
        .nrst_out      (nrst_out),
        .trig_inhibit  (trig_inhibit),
        .busy          (busy),
        .ready_pulse   (ready_pulse),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase number plus cycles spent in it versus the dwell fixed at entry.
    int m_ph = 0;
    int m_el = 0;
    int m_dw = 1;
    int m_nx;
    bit m_rdy = 1'b0;

    function automatic int dwell_for(input int ph);
        int c;
        case (ph)
            1:       c = int'(settle_cycles);
            2:       c = int'(rst_cycles);
            4:       c = int'(off_cycles);
            default: c = 1;
        endcase
        return (c < 1) ? 1 : c;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph  = 0;
            m_el  = 0;
            m_dw  = 1;
            m_rdy = 1'b0;
        end else begin
            m_nx = m_ph;
            case (m_ph)
                0: if (pwr_en) m_nx = 1;
                1: if (!pwr_en) m_nx = 4; else if (m_el >= m_dw) m_nx = autorst ? 2 : 3;
                2: if (!pwr_en) m_nx = 4; else if (m_el >= m_dw) m_nx = 3;
                3: if (!pwr_en) m_nx = 4; else if (rst_req) m_nx = 2;
                4: if (m_el >= m_dw) m_nx = 0;
                default: m_nx = 0;
            endcase
            m_rdy = (m_nx == 3) && (m_ph != 3);
            if (m_nx != m_ph) begin
                m_dw = dwell_for(m_nx);
                m_el = 1;
            end else begin
                m_el++;
            end
            m_ph = m_nx;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            check("state", int'(state_o), m_ph);
            check("npower", int'(target_npower), int'(m_ph == 0 || m_ph == 4));
            check("highz", int'(target_highz), int'(m_ph == 0 || m_ph == 4));
            check("drive_en", int'(nrst_drive_en), int'(m_ph == 1 || m_ph == 2));
            if (m_ph == 1 || m_ph == 2) check("nrst_out", int'(nrst_out), 0);
            check("inhibit", int'(trig_inhibit), int'(m_ph != 3));
            check("busy", int'(busy), int'(m_ph == 1 || m_ph == 2 || m_ph == 4));
            check("ready", int'(ready_pulse), int'(m_rdy));
        end
    end

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state_o != s && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", int'(state_o), int'(s));
    endtask

    // Runs until ON, counting nRST-low cycles; optionally pulses rst_req on one iteration.
    task automatic run_until_on(input int pulse_at, output int low, output int cyc);
        bit reached = 1'b0;
        low = 0;
        cyc = 0;
        while (!reached && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (state_o == 3'd3) begin
                reached = 1'b1;
            end else begin
                if (nrst_drive_en && !nrst_out) low++;
                rst_req = (cyc == pulse_at);
            end
        end
        rst_req = 1'b0;
        check("on_reached", int'(reached), 1);
    endtask

    int low;
    int cyc;
    int cnt;

    initial begin
        reset_n       = 1'b0;
        pwr_en        = 1'b0;
        autorst       = 1'b0;
        rst_req       = 1'b0;
        settle_cycles = CNT_W'(5);
        rst_cycles    = CNT_W'(4);
        off_cycles    = CNT_W'(2);
        repeat (3) @(negedge clk);
        check("rst_npower", int'(target_npower), 1);
        check("rst_highz", int'(target_highz), 1);
        check("rst_drive_en", int'(nrst_drive_en), 0);
        check("rst_nrst_out", int'(nrst_out), 1);
        check("rst_inhibit", int'(trig_inhibit), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(ready_pulse), 0);
        check("rst_state", int'(state_o), 0);
        reset_n = 1'b1;

        // Idle with power off.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_state", int'(state_o), 0);
            check("idle_npower", int'(target_npower), 1);
        end

        // Plain power-up, settle=5.
        pwr_en = 1'b1;
        run_until_on(-1, low, cyc);
        check("pu_low_cycles", low, 5);
        check("pu_ready_cycle", cyc, 6);
        check("pu_ready", int'(ready_pulse), 1);
        check("pu_inhibit", int'(trig_inhibit), 0);
        @(negedge clk);
        check("pu_ready_once", int'(ready_pulse), 0);

        // Power-up with auto reset: 3 + 4 cycles low.
        pwr_en = 1'b0;
        wait_state(3'd0);
        settle_cycles = CNT_W'(3);
        rst_cycles    = CNT_W'(4);
        autorst       = 1'b1;
        pwr_en        = 1'b1;
        run_until_on(-1, low, cyc);
        check("ar_low_cycles", low, 7);
        check("ar_ready", int'(ready_pulse), 1);

        // Reset pulse from ON with rst=0 behaves as one cycle.
        rst_cycles = CNT_W'(0);
        rst_req    = 1'b1;
        @(negedge clk);
        rst_req = 1'b0;
        check("rp_state", int'(state_o), 2);
        check("rp_nrst", int'(nrst_out), 0);
        @(negedge clk);
        check("rp_back_on", int'(state_o), 3);
        check("rp_ready", int'(ready_pulse), 1);

        // rst_req during SETTLE is dropped.
        pwr_en = 1'b0;
        wait_state(3'd0);
        settle_cycles = CNT_W'(6);
        autorst       = 1'b0;
        pwr_en        = 1'b1;
        run_until_on(2, low, cyc);
        check("sr_low_cycles", low, 6);

        // Power drop with immediate re-request: 8 discharge + 1 off.
        off_cycles = CNT_W'(8);
        pwr_en     = 1'b0;
        @(negedge clk);
        pwr_en = 1'b1;
        cnt    = 1;
        while (state_o != 3'd1 && cnt < 100) begin
            @(negedge clk);
            if (state_o != 3'd1 && target_npower) cnt++;
        end
        check("dis_npower_cycles", cnt, 9);

        // Asynchronous reset during RST_HOLD.
        autorst    = 1'b1;
        rst_cycles = CNT_W'(20);
        wait_state(3'd2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_npower", int'(target_npower), 1);
        check("ar_drive_en", int'(nrst_drive_en), 0);
        check("ar_state", int'(state_o), 0);
        check("ar_highz", int'(target_highz), 1);
        pwr_en = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_ready", int'(ready_pulse), 0);
            check("post_rst_state", int'(state_o), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/target_pwr_seq.md
# target_pwr_seq

Target power/reset sequencer between the register block and the target-facing pins (target power switch, target nRST tri-state). It turns a software power request into a timed sequence: power on, hold nRST low, release, and enforce a minimum off time on power-down. It also issues on-demand reset pulses and raises a capture/glitch trigger inhibit while the target is not in a stable powered state.

## Interface
Parameters:
- CNT_W, 24, width of all delay counters and cycle-count configuration inputs.

Ports:
- clk  in  1  system clock (USB interface clock domain).
- reset_n  in  1  asynchronous, active-low reset.
- pwr_en  in  1  level; 1 = target power requested.
- autorst  in  1  level; 1 = insert RST_HOLD after SETTLE on power-up.
- rst_req  in  1  single-cycle reset-pulse request.
- settle_cycles  in  CNT_W  power-on settle time, nRST held low.
- rst_cycles  in  CNT_W  nRST low time for RST_HOLD.
- off_cycles  in  CNT_W  minimum power-off (discharge) time.
- target_npower  out  1  active-low power switch drive.
- target_highz  out  1  1 = all target I/O must float.
- nrst_drive_en  out  1  1 = drive target nRST.
- nrst_out  out  1  nRST value when driven.
- trig_inhibit  out  1  1 = block capture and glitch triggers.
- busy  out  1  sequence in progress (not OFF, not ON).
- ready_pulse  out  1  one-cycle pulse on entry to ON.
- state_o  out  3  current state encoding, for register readback.

## Operation
- States: OFF=0, SETTLE=1, RST_HOLD=2, ON=3, DISCHARGE=4.
- OFF: npower=1, highz=1, drive_en=0, inhibit=1. If pwr_en=1, go to SETTLE.
- SETTLE: npower=0, highz=0, drive_en=1, nrst_out=0, inhibit=1.
  - If pwr_en=0, go to DISCHARGE.
  - When the count expires, go to RST_HOLD if autorst=1, else to ON.
- RST_HOLD: same outputs as SETTLE.
  - If pwr_en=0, go to DISCHARGE.
  - When the count expires, go to ON.
- ON: npower=0, highz=0, drive_en=0 (nRST released to its pull-up), inhibit=0.
  - If pwr_en=0, go to DISCHARGE. This has priority over rst_req.
  - Else if rst_req=1, go to RST_HOLD.
- DISCHARGE: npower=1, highz=1, drive_en=0, inhibit=1.
  - When the count expires, go to OFF.
  - pwr_en is ignored until then. If pwr_en is still 1 on entry to OFF, the next cycle goes to SETTLE.
- rst_req outside ON is dropped. It is not queued.
- Counter: one shared down-counter.
  - On state entry it loads max(cfg,1)-1, where cfg is the count input for the new state. A cfg of 0 is treated as 1.
  - The state exits when the counter is 0, so dwell time is exactly max(cfg,1) cycles.
  - Configuration inputs are sampled only at entry. Changing them mid-state has no effect.
- busy=1 in SETTLE, RST_HOLD and DISCHARGE.
- ready_pulse: 1 for exactly the first cycle of ON, after both SETTLE and RST_HOLD paths.

## Timing
- All outputs are registered and decoded from the registered state. There is no combinational path from inputs to outputs.
- Input-to-output latency is one cycle: pwr_en sampled 1 at edge N gives npower=0 after edge N.
- Reset values (reset_n=0, asynchronous): state=OFF, npower=1, highz=1, drive_en=0, nrst_out=1, inhibit=1, busy=0, ready_pulse=0, counter=0.
- Reset asserted mid-sequence: power is cut immediately (asynchronous) and the block returns to OFF. No DISCHARGE time is enforced after reset.
- reset_n deassertion is synchronised externally. The block does not re-synchronise it.
- Simultaneous pwr_en falling and counter expiry in SETTLE or RST_HOLD: DISCHARGE wins.
- Counter never wraps: it holds at 0 while in ON or OFF.

## Structure
- Package target_seq_pkg:
  - state enum and its 3-bit encodings.
  - DEF_SETTLE=1000, DEF_RST=100, DEF_OFF=10000 (register-block reset defaults).
- Sub-module seq_down_counter (load, load_val, zero flag), parameterised by CNT_W.
- Everything else is in one FSM module.

## Test plan
- Reset release, pwr_en=0 for 20 cycles -> npower=1, highz=1, drive_en=0, state_o=0 throughout.
- settle=5, autorst=0, pwr_en set at cycle 0 -> npower=0 from cycle 1, nrst driven low for exactly 5 cycles, ready_pulse at cycle 6, inhibit=0 from cycle 6.
- settle=3, rst=4, autorst=1 -> nrst low 7 consecutive cycles, then state 3 with one ready_pulse.
- In ON, rst_req pulse, rst=0 -> 1 cycle of nrst low, ready_pulse again; rst_req while state=1 -> ignored, SETTLE length unchanged.
- off=8, pwr_en dropped in ON, re-asserted next cycle -> npower=1 for 9 cycles (8 DISCHARGE + 1 OFF), then SETTLE.
- reset_n pulsed low mid-RST_HOLD -> npower=1 and drive_en=0 asynchronously, state_o=0; no ready_pulse.
